// File: rtl/icache_if.sv
// icache_if -- bundle of the instruction-cache datapath and memory-side signals.
//
// Datapath side : imemREN, imemaddr, flush (into the cache)
//                 ihit, imemload, miss_count (out of the cache)
// Memory side   : iREN, iaddr (out of the cache)
//                 iwait, iload (into the cache)
//
// slave  : the cache's view (icache instantiates this modport)
// master : the environment's view (datapath + instruction memory)
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [15:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr, miss_count
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, miss_count
  );
endinterface

// File: rtl/icache.sv
// icache -- direct-mapped, read-only instruction cache with one 32-bit word
// per frame and 2**INDEX_BITS frames.
//
// Ports:
//   CLK   : clock, all state updates on the rising edge
//   nRST  : asynchronous active-low reset
//   bus   : icache_if.slave
//             imemREN/imemaddr -> fetch request, ihit/imemload <- same-cycle hit
//             iREN/iaddr -> memory read, iwait/iload <- memory response
//             flush -> invalidate all frames, miss_count <- saturating miss count
//
// A hit is answered combinationally in IDLE. A miss latches the word address
// and moves to FILL, which holds iREN until memory drops iwait; the frame is
// written on that edge and the re-presented fetch hits one cycle later.
module icache #(
  parameter int INDEX_BITS = 4
) (
  input logic CLK,
  input logic nRST,
  icache_if.slave bus
);
  localparam int FRAMES = 1 << INDEX_BITS;
  localparam int TAG_W  = 30 - INDEX_BITS;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [29:0]          addr_q, addr_d;        // latched {tag, index}
  logic [15:0]          miss_count_q, miss_count_d;
  logic [FRAMES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [FRAMES];
  logic [31:0]          data_q [FRAMES];

  logic [INDEX_BITS-1:0] req_index, fill_index;
  logic [TAG_W-1:0]      req_tag, fill_tag;
  logic                  hit, miss, fill_done;
  logic                  unused_addr_bits;

  assign req_index  = bus.imemaddr[INDEX_BITS+1:2];
  assign req_tag    = bus.imemaddr[31:INDEX_BITS+2];
  assign fill_index = addr_q[INDEX_BITS-1:0];
  assign fill_tag   = addr_q[29:INDEX_BITS];
  assign unused_addr_bits = ^bus.imemaddr[1:0];

  // Hit/miss only look at cache state, never at iload/iwait.
  assign hit  = (state_q == IDLE) && bus.imemREN && valid_q[req_index]
                && (tag_q[req_index] == req_tag);
  assign miss = (state_q == IDLE) && bus.imemREN && !hit;
  assign fill_done = (state_q == FILL) && !bus.iwait;

  // Flush is applied after the fill write so a coincident flush leaves the
  // freshly filled frame invalid.
  genvar gi;
  generate
    for (gi = 0; gi < FRAMES; gi++) begin : g_valid
      assign valid_d[gi] = bus.flush ? 1'b0 :
                           (fill_done && (fill_index == INDEX_BITS'(gi))) ? 1'b1 :
                           valid_q[gi];
    end
  endgenerate

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      miss_count_q <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      miss_count_q <= miss_count_d;
      valid_q      <= valid_d;
    end
  end

  // Tag/data need no reset: the valid bits guard them.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= bus.iload;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    miss_count_d = miss_count_q;
    case (state_q)
      IDLE: begin
        if (miss) begin
          state_d = FILL;
          addr_d  = bus.imemaddr[31:2];
          if (miss_count_q != 16'hFFFF) begin
            miss_count_d = miss_count_q + 16'd1;
          end
        end
      end
      FILL: begin
        if (!bus.iwait) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    if (hit) begin
      bus.ihit     = 1'b1;
      bus.imemload = data_q[req_index];
    end
    if (state_q == FILL) begin
      bus.iREN  = 1'b1;
      bus.iaddr = {addr_q, 2'b00};
    end
  end

  assign bus.miss_count = miss_count_q;

endmodule

// File: tb/tb_icache.sv
// tb_icache -- directed scenarios plus randomized traffic for icache, checked
// every cycle against a frame-array reference model kept in the bench.
module tb_icache;
  logic clk;
  logic nrst;

  icache_if bus ();

  icache #(.INDEX_BITS(4)) dut (
    .CLK (clk),
    .nRST(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: 16 frames, word address split by plain arithmetic
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  bit          m_busy;
  logic [29:0] m_fill;
  int          m_misses;

  bit last_ihit;
  int iren_cycles;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    return ({w, 2'b00} * 32'h9E37_79B1) ^ 32'hA5C3_0F96;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_busy   = 1'b0;
    m_fill   = '0;
    m_misses = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, take the
  // edge, then advance the model with the same inputs.
  task automatic step(input bit ren, input logic [31:0] addr, input bit fl,
                      input bit wt, input logic [31:0] ld);
    logic [29:0] w;
    int          idx;
    bit          exp_hit;
    logic [31:0] exp_load;
    w = addr[31:2];
    idx = int'(w % 16);
    bus.imemREN  = ren;
    bus.imemaddr = addr;
    bus.flush    = fl;
    bus.iwait    = wt;
    bus.iload    = ld;
    exp_hit  = !m_busy && ren && m_valid[idx] && (m_tag[idx] == 26'(w / 16));
    exp_load = exp_hit ? m_data[idx] : 32'h0;
    #1;
    check_eq("ihit", 32'(bus.ihit), 32'(exp_hit));
    check_eq("imemload", bus.imemload, exp_load);
    check_eq("iREN", 32'(bus.iREN), 32'(m_busy));
    check_eq("iaddr", bus.iaddr, m_busy ? {m_fill, 2'b00} : 32'h0);
    check_eq("miss_count", 32'(bus.miss_count), 32'(m_misses));
    last_ihit = bus.ihit;
    if (bus.iREN) iren_cycles++;
    if (bus.ihit) $display("fetch %h hit data %h", addr, bus.imemload);
    @(posedge clk);
    #1;
    if (m_busy) begin
      if (!wt) begin
        m_valid[m_fill % 16] = 1'b1;
        m_tag[m_fill % 16]   = 26'(m_fill / 16);
        m_data[m_fill % 16]  = ld;
        m_busy = 1'b0;
      end
    end else if (ren && !exp_hit) begin
      m_busy = 1'b1;
      m_fill = w;
      if (m_misses < 65535) m_misses++;
    end
    if (fl) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // miss cycle, 'waits' busy cycles, completion cycle (optionally flushed)
  task automatic fill(input logic [31:0] addr, input int waits,
                      input logic [31:0] ld, input bit fl_last);
    step(1'b1, addr, 1'b0, 1'b0, ld);
    for (int i = 0; i < waits; i++) step(1'b1, addr, 1'b0, 1'b1, ld);
    step(1'b1, addr, fl_last, 1'b0, ld);
  endtask

  // Reset pulse placed between edges; outputs must drop immediately.
  task automatic pulse_reset();
    bus.imemREN = 1'b0;
    bus.flush   = 1'b0;
    nrst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_iREN", 32'(bus.iREN), 32'(m_busy));
    check_eq("rst_iaddr", bus.iaddr, 32'h0);
    check_eq("rst_ihit", 32'(bus.ihit), 32'h0);
    check_eq("rst_miss_count", 32'(bus.miss_count), 32'(m_misses));
    #1;
    nrst = 1'b1;
    $display("reset pulse at %0t", $time);
  endtask

  initial begin
    logic [31:0] a;
    bit ren, fl, wt;
    nrst = 1'b0;
    bus.imemREN = 1'b0;
    bus.imemaddr = '0;
    bus.flush = 1'b0;
    bus.iwait = 1'b1;
    bus.iload = '0;
    model_reset();
    #2;
    check_eq("reset_ihit", 32'(bus.ihit), 32'h0);
    check_eq("reset_imemload", bus.imemload, 32'h0);
    check_eq("reset_iREN", 32'(bus.iREN), 32'h0);
    check_eq("reset_iaddr", bus.iaddr, 32'h0);
    check_eq("reset_miss_count", 32'(bus.miss_count), 32'h0);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // cold fetch with three wait cycles
    iren_cycles = 0;
    fill(32'h40, 3, 32'h8C01_0004, 1'b0);
    check_eq("cold_iren_cycles", 32'(iren_cycles), 32'd4);
    check_eq("cold_miss_count", 32'(bus.miss_count), 32'd1);
    step(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    check_eq("cold_refetch_hit", 32'(last_ihit), 32'd1);
    $display("cold fetch 0x40 done, misses %0d", bus.miss_count);

    // repeat fetch hits with no memory traffic
    iren_cycles = 0;
    step(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    check_eq("repeat_hit", 32'(last_ihit), 32'd1);
    check_eq("repeat_iren", 32'(iren_cycles), 32'd0);
    check_eq("repeat_miss_count", 32'(bus.miss_count), 32'd1);

    // conflicting tag on index 0 replaces the frame
    fill(32'h440, 1, 32'h1111_2222, 1'b0);
    step(1'b1, 32'h440, 1'b0, 1'b1, 32'h0);
    check_eq("conflict_hit", 32'(last_ihit), 32'd1);
    step(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    check_eq("evicted_miss", 32'(last_ihit), 32'd0);
    step(1'b1, 32'h40, 1'b0, 1'b0, 32'h8C01_0004);
    check_eq("conflict_miss_count", 32'(bus.miss_count), 32'd3);

    // flush on the fill-completion edge wins
    fill(32'h84, 2, 32'h3333_4444, 1'b1);
    step(1'b1, 32'h84, 1'b0, 1'b0, 32'h3333_4444);
    check_eq("flush_fill_miss", 32'(last_ihit), 32'd0);
    step(1'b1, 32'h84, 1'b0, 1'b0, 32'h3333_4444);

    // address moves / request drops during the fill
    step(1'b1, 32'h40, 1'b0, 1'b1, 32'h5555_6666);
    step(1'b1, 32'h80, 1'b0, 1'b1, 32'h5555_6666);
    check_eq("moved_iaddr", bus.iaddr, 32'h40);
    step(1'b0, 32'h80, 1'b0, 1'b0, 32'h5555_6666);
    step(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    check_eq("moved_filled_hit", 32'(last_ihit), 32'd1);
    step(1'b1, 32'h80, 1'b0, 1'b0, 32'h7777_8888);
    check_eq("moved_next_miss", 32'(last_ihit), 32'd0);
    step(1'b1, 32'h80, 1'b0, 1'b0, 32'h7777_8888);

    // flush while waiting, and flush alongside an IDLE miss
    step(1'b1, 32'h8, 1'b1, 1'b1, 32'h0);
    step(1'b1, 32'h8, 1'b1, 1'b1, 32'h9999_AAAA);
    step(1'b1, 32'h8, 1'b0, 1'b0, 32'h9999_AAAA);
    step(1'b1, 32'h8, 1'b0, 1'b1, 32'h0);
    check_eq("flush_wait_valid", 32'(last_ihit), 32'd1);

    // reset pulsed mid-fill
    step(1'b1, 32'h104, 1'b0, 1'b1, 32'hBBBB_CCCC);
    step(1'b1, 32'h104, 1'b0, 1'b1, 32'hBBBB_CCCC);
    pulse_reset();
    check_eq("midfill_rst_count", 32'(bus.miss_count), 32'd0);
    step(1'b1, 32'h8, 1'b0, 1'b1, 32'h0);
    check_eq("post_rst_miss", 32'(last_ihit), 32'd0);
    step(1'b1, 32'h8, 1'b0, 1'b0, mem_word(30'h2));

    // randomized traffic over a small address pool so hits are frequent
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      a   = {26'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      ren = ($urandom_range(0, 9) < 8);
      fl  = ($urandom_range(0, 39) == 0);
      wt  = ($urandom_range(0, 1) == 1);
      step(ren, a, fl, wt, m_busy ? mem_word(m_fill) : $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 4, meaning log2 of frame count (16 frames of one 32-bit word, direct-mapped).
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 imemREN  input  1  datapath fetch request.
REQ-005 imemaddr  input  32  datapath fetch byte address; bits [1:0] ignored.
REQ-006 flush  input  1  synchronous invalidate-all request.
REQ-007 ihit  output  1  fetch request served this cycle.
REQ-008 imemload  output  32  instruction word, valid when ihit=1.
REQ-009 iREN  output  1  memory-side read request.
REQ-010 iaddr  output  32  memory-side word address, bits [1:0] = 0.
REQ-011 iwait  input  1  memory busy; iload not valid while 1.
REQ-012 iload  input  32  memory read data, valid when iREN=1 and iwait=0.
REQ-013 miss_count  output  16  number of misses since reset, saturating.

Function
REQ-014 Address split SHALL be: index = imemaddr[INDEX_BITS+1:2], tag = imemaddr[31:INDEX_BITS+2].
REQ-015 Each frame SHALL hold valid bit, tag and 32-bit data; storage SHALL be registers.
REQ-016 FSM SHALL have two states, IDLE and FILL.
REQ-017 Hit (IDLE, imemREN=1, valid[index]=1, stored tag equals tag): ihit=1 and imemload=data[index] combinationally, same cycle, with no memory request.
REQ-018 imemload SHALL be 0 whenever ihit=0.
REQ-019 Miss (IDLE, imemREN=1, no hit): ihit=0; next edge SHALL latch {tag,index}, enter FILL and increment miss_count (hold at 16'hFFFF).
REQ-020 IDLE with imemREN=0: ihit=0, iREN=0, iaddr=0, no state change.
REQ-021 FILL: iREN=1, iaddr = latched address with [1:0]=0, ihit=0, independent of imemREN/imemaddr.
REQ-022 FILL with iwait=1: remain in FILL, hold latched address.
REQ-023 FILL with iwait=0: at edge write frame (valid=1, tag, data=iload), return to IDLE; the re-presented address hits in the following cycle (miss penalty = 1 + memory wait cycles + 1).
REQ-024 Changes of imemaddr or deassertion of imemREN during FILL SHALL NOT abort the fill; the latched block is still written.
REQ-025 A fill SHALL overwrite any valid frame at the same index (no write-back; instruction side is read-only).
REQ-026 flush=1 SHALL clear every valid bit at the edge; tags/data need not be cleared; hits SHALL still be reported in the flush cycle per current contents.
REQ-027 flush=1 in IDLE with a miss: the miss SHALL still transition to FILL and count.
REQ-028 flush=1 in the same cycle as fill completion: flush wins, the filled frame SHALL end invalid, FSM returns to IDLE.
REQ-029 flush=1 during FILL with iwait=1: fill continues; completed frame SHALL be valid.
REQ-030 No combinational path from iload/iwait to ihit/imemload.

Reset
REQ-031 On nRST=0, immediately: all valid bits 0, FSM IDLE, latched address 0, miss_count 0; hence ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-032 Reset asserted mid-FILL SHALL abandon the fill with no frame written.

Verification
REQ-033 Cold fetch 0x00000040, iwait=1 for 3 cycles then iload=0x8C010004 -> miss_count=1, iREN high 4 cycles at iaddr 0x40, ihit=1/imemload=0x8C010004 next cycle.
REQ-034 Repeat fetch 0x40 -> ihit=1 same cycle, iREN=0, miss_count unchanged.
REQ-035 Fetch 0x00000440 (same index 0, different tag) after 0x40 -> miss, frame replaced; then 0x40 misses again, miss_count=3.
REQ-036 flush asserted on fill-completion edge -> frame invalid, next fetch of same address misses.
REQ-037 Address changed to 0x80 while filling 0x40 -> iaddr stays 0x40, frame 0 filled, then 0x80 misses.
REQ-038 nRST pulsed mid-FILL -> iREN=0 immediately, miss_count=0, prior hits now miss.
